escalonador_chamadas: RTL and testbench



---
 rtl/escalonador_chamadas_pkg.sv | 15 +
 rtl/escalonador_chamadas_seletor.sv | 41 ++++
 rtl/escalonador_chamadas.sv | 120 ++++++++++++
 tb/tb_escalonador_chamadas.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_chamadas_pkg.sv
// Shared definitions for the elevator call scheduler: floor width, floor count,
// scheduler state encoding and direction constants.
package pkg_elevador;
  localparam int ANDAR_W     = 2;
  localparam int NUM_ANDARES = 4;

  typedef enum logic [1:0] {
    OCIOSO       = 2'b00,
    MOVENDO      = 2'b01,
    PORTA_ABERTA = 2'b10
  } estado_t;

  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;
endpackage

// File: rtl/escalonador_chamadas_seletor.sv
// SCAN next-floor selector: prefers calls in the current travel direction and
// reports a direction flip only when nothing remains ahead.
module seletor_proximo_andar
  import pkg_elevador::*;
(
  input  logic [NUM_ANDARES-1:0] req,
  input  logic [ANDAR_W-1:0]     andar_atual,
  input  logic                   subindo,
  output logic                   valido,
  output logic [ANDAR_W-1:0]     prox,
  output logic                   inverte
);
  logic               lo_ge_v, lo_gt_v, hi_le_v, hi_lt_v;
  logic [ANDAR_W-1:0] lo_ge, lo_gt, hi_le, hi_lt;

  // Descending scan keeps the lowest hit, ascending scan keeps the highest.
  always_comb begin
    lo_ge_v = 1'b0; lo_gt_v = 1'b0; hi_le_v = 1'b0; hi_lt_v = 1'b0;
    lo_ge = '0; lo_gt = '0; hi_le = '0; hi_lt = '0;
    for (int i = NUM_ANDARES-1; i >= 0; i--) begin
      if (req[i] && i >= int'(andar_atual)) begin lo_ge_v = 1'b1; lo_ge = ANDAR_W'(i); end
      if (req[i] && i >  int'(andar_atual)) begin lo_gt_v = 1'b1; lo_gt = ANDAR_W'(i); end
    end
    for (int i = 0; i < NUM_ANDARES; i++) begin
      if (req[i] && i <= int'(andar_atual)) begin hi_le_v = 1'b1; hi_le = ANDAR_W'(i); end
      if (req[i] && i <  int'(andar_atual)) begin hi_lt_v = 1'b1; hi_lt = ANDAR_W'(i); end
    end
  end

  always_comb begin
    if (subindo == SOBE) begin
      valido  = lo_ge_v | hi_lt_v;
      inverte = !lo_ge_v && hi_lt_v;
      prox    = lo_ge_v ? lo_ge : hi_lt;
    end else begin
      valido  = hi_le_v | lo_gt_v;
      inverte = !hi_le_v && lo_gt_v;
      prox    = hi_le_v ? hi_le : lo_gt;
    end
  end
endmodule

// File: rtl/escalonador_chamadas.sv
// Elevator call scheduler: latches floor calls, picks targets with SCAN and
// times the door dwell, holding the door while the capacity alert is up.
module escalonador_chamadas #(
  parameter int NUM_ANDARES = 4,
  parameter int TEMPO_PORTA = 8,
  parameter int LARG_TEMPO  = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_ANDARES-1:0] chamada,
  input  logic [1:0]             andar_atual,
  input  logic                   alerta_capacidade,
  output logic [1:0]             andar_destino,
  output logic [NUM_ANDARES-1:0] pendentes,
  output logic                   porta_aberta,
  output logic                   subindo,
  output logic                   parado
);
  import pkg_elevador::*;

  localparam logic [LARG_TEMPO-1:0] TEMPO_EF =
    (TEMPO_PORTA < 1) ? LARG_TEMPO'(1) : LARG_TEMPO'(TEMPO_PORTA);
  localparam logic [LARG_TEMPO-1:0]  UM_T = LARG_TEMPO'(1);
  localparam logic [NUM_ANDARES-1:0] UM_A = NUM_ANDARES'(1);

  estado_t                 estado;
  logic [LARG_TEMPO-1:0]   timer;
  logic [NUM_ANDARES-1:0]  req, limpa;
  logic                    valido, inverte, aqui, chegou, abre;
  logic [1:0]              prox;

  // A call arriving this cycle counts immediately, giving 1-cycle decisions.
  assign req    = pendentes | chamada;
  assign aqui   = req[andar_atual];
  assign chegou = (andar_atual == andar_destino);

  // High on any cycle whose next state is PORTA_ABERTA.
  always_comb begin
    abre = 1'b0;
    case (estado)
      OCIOSO:       abre = aqui;
      MOVENDO:      abre = chegou;
      PORTA_ABERTA: abre = chamada[andar_atual] || alerta_capacidade || (timer > UM_T);
      default:      abre = 1'b0;
    endcase
  end

  assign limpa = abre ? (UM_A << andar_atual) : '0;

  seletor_proximo_andar u_seletor (
    .req         (req),
    .andar_atual (andar_atual),
    .subindo     (subindo),
    .valido      (valido),
    .prox        (prox),
    .inverte     (inverte)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado        <= OCIOSO;
      pendentes     <= '0;
      andar_destino <= '0;
      porta_aberta  <= 1'b0;
      subindo       <= SOBE;
      parado        <= 1'b1;
      timer         <= '0;
    end else begin
      pendentes <= req & ~limpa;
      case (estado)
        OCIOSO: begin
          if (aqui) begin
            estado        <= PORTA_ABERTA;
            timer         <= TEMPO_EF;
            porta_aberta  <= 1'b1;
            andar_destino <= andar_atual;
          end else if (valido) begin
            estado        <= MOVENDO;
            andar_destino <= prox;
            parado        <= 1'b0;
            if (inverte) subindo <= ~subindo;
          end else begin
            andar_destino <= andar_atual;
          end
        end
        MOVENDO: begin
          if (chegou) begin
            estado       <= PORTA_ABERTA;
            timer        <= TEMPO_EF;
            porta_aberta <= 1'b1;
            parado       <= 1'b1;
          end else if (valido) begin
            // Direction is never flipped while travelling.
            andar_destino <= prox;
          end
        end
        PORTA_ABERTA: begin
          andar_destino <= andar_atual;
          if (chamada[andar_atual]) begin
            timer <= TEMPO_EF;
          end else if (!alerta_capacidade) begin
            if (timer <= UM_T) begin
              estado       <= OCIOSO;
              porta_aberta <= 1'b0;
              timer        <= '0;
            end else begin
              timer <= timer - UM_T;
            end
          end
        end
        default: begin
          estado       <= OCIOSO;
          porta_aberta <= 1'b0;
          parado       <= 1'b1;
          timer        <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_escalonador_chamadas.sv
// Directed and random stimulus for the call scheduler, checked every cycle
// against a floor-list reference model of the scheduling rules.
module tb_escalonador_chamadas;
  localparam int TEMPO = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] chamada;
  logic [1:0] andar_atual;
  logic       alerta_capacidade;
  logic [1:0] andar_destino;
  logic [3:0] pendentes;
  logic       porta_aberta, subindo, parado;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 travelling, 2 door open.
  bit [3:0] m_pend;
  int       m_st, m_dest, m_timer;
  bit       m_open, m_up;
  int       cur;

  escalonador_chamadas #(.NUM_ANDARES(4), .TEMPO_PORTA(TEMPO), .LARG_TEMPO(8)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .chamada           (chamada),
    .andar_atual       (andar_atual),
    .alerta_capacidade (alerta_capacidade),
    .andar_destino     (andar_destino),
    .pendentes         (pendentes),
    .porta_aberta      (porta_aberta),
    .subindo           (subindo),
    .parado            (parado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_st = 0; m_dest = 0; m_timer = 0; m_open = 0; m_up = 1;
  endtask

  // Walk outward from the current floor: travel direction first, then the other way.
  task automatic scan(input bit [3:0] r, input int at, input bit up,
                      output bit v, output int p, output bit flip);
    v = 0; p = 0; flip = 0;
    if (up) begin
      for (int f = at; f <= 3; f++) if (r[f] && !v) begin v = 1; p = f; end
      for (int f = at - 1; f >= 0; f--) if (r[f] && !v) begin v = 1; p = f; flip = 1; end
    end else begin
      for (int f = at; f >= 0; f--) if (r[f] && !v) begin v = 1; p = f; end
      for (int f = at + 1; f <= 3; f++) if (r[f] && !v) begin v = 1; p = f; flip = 1; end
    end
  endtask

  task automatic model_step(input bit [3:0] ch, input int at, input bit al);
    bit [3:0] r;
    bit v, flip;
    int p, nxt;
    r = m_pend | ch;
    scan(r, at, m_up, v, p, flip);
    nxt = m_st;
    if (m_st == 0) begin
      if (r[at]) begin nxt = 2; m_timer = TEMPO; m_open = 1; m_dest = at; end
      else if (v) begin nxt = 1; m_dest = p; if (flip) m_up = !m_up; end
      else m_dest = at;
    end else if (m_st == 1) begin
      if (at == m_dest) begin nxt = 2; m_timer = TEMPO; m_open = 1; end
      else if (v) m_dest = p;
    end else begin
      m_dest = at;
      if (ch[at]) m_timer = TEMPO;
      else if (!al) begin
        if (m_timer == 1) begin nxt = 0; m_open = 0; m_timer = 0; end
        else m_timer = m_timer - 1;
      end
    end
    m_pend = r;
    if (nxt == 2) m_pend[at] = 1'b0;
    m_st = nxt;
  endtask

  task automatic tick(input logic [3:0] ch, input logic [1:0] at, input logic al);
    logic [8:0] exp;
    logic [1:0] d;
    chamada = ch; andar_atual = at; alerta_capacidade = al;
    @(posedge clock); #1;
    model_step(ch, int'(at), al);
    d = m_dest[1:0];
    exp = {d, m_pend, m_open, m_up, (m_st != 1)};
    chk("ciclo", 32'({andar_destino, pendentes, porta_aberta, subindo, parado}), 32'(exp));
    if (porta_aberta && !parado) chk("porta_implica_parado", 32'(parado), 32'd1);
  endtask

  task automatic espera_porta(input logic [1:0] at, output int n);
    n = 0;
    while (porta_aberta && n < 60) begin tick(4'b0000, at, 1'b0); n++; end
  endtask

  initial begin
    int n;
    logic [3:0] ch;
    logic al;
    reset_n = 1'b0; chamada = '0; andar_atual = '0; alerta_capacidade = 1'b0;
    model_reset();
    #12;
    chk("reset", 32'({andar_destino, pendentes, porta_aberta, subindo, parado}), 32'h003);
    reset_n = 1'b1;

    // Idle at 0, call to 3, travel and dwell.
    tick(4'b1000, 2'd0, 1'b0);
    chk("destino_3", 32'({andar_destino, subindo, parado}), 32'b11_1_0);
    tick(4'b0000, 2'd1, 1'b0);
    tick(4'b0000, 2'd2, 1'b0);
    tick(4'b0000, 2'd3, 1'b0);
    chk("abre_3", 32'({porta_aberta, pendentes}), 32'b1_0000);
    espera_porta(2'd3, n);
    chk("dwell_3", 32'(n), 32'(TEMPO));

    // Go down to 1, then up to 3 with an intermediate stop at 2.
    tick(4'b0010, 2'd3, 1'b0);
    chk("desce_1", 32'({andar_destino, subindo}), 32'b01_0);
    tick(4'b0000, 2'd2, 1'b0);
    tick(4'b0000, 2'd1, 1'b0);
    espera_porta(2'd1, n);
    tick(4'b1000, 2'd1, 1'b0);
    chk("sobe_3", 32'({andar_destino, subindo}), 32'b11_1);
    tick(4'b0100, 2'd1, 1'b0);
    chk("parada_2", 32'(andar_destino), 32'd2);
    tick(4'b0000, 2'd2, 1'b0);
    chk("abre_2", 32'({porta_aberta, pendentes}), 32'b1_1000);
    espera_porta(2'd2, n);
    chk("dwell_2", 32'(n), 32'(TEMPO));
    tick(4'b0000, 2'd2, 1'b0);
    chk("retoma_3", 32'(andar_destino), 32'd3);
    tick(4'b0000, 2'd3, 1'b0);
    espera_porta(2'd3, n);

    // Reach 2 going up, latch 0 and 3: serve 3 then reverse to 0.
    tick(4'b0001, 2'd3, 1'b0);
    tick(4'b0000, 2'd2, 1'b0);
    tick(4'b0000, 2'd1, 1'b0);
    tick(4'b0000, 2'd0, 1'b0);
    espera_porta(2'd0, n);
    tick(4'b0100, 2'd0, 1'b0);
    tick(4'b0000, 2'd1, 1'b0);
    tick(4'b0000, 2'd2, 1'b0);
    tick(4'b1001, 2'd2, 1'b0);
    chk("latch_0_3", 32'(pendentes), 32'b1001);
    espera_porta(2'd2, n);
    tick(4'b0000, 2'd2, 1'b0);
    chk("scan_3_primeiro", 32'({andar_destino, subindo}), 32'b11_1);
    tick(4'b0000, 2'd3, 1'b0);
    espera_porta(2'd3, n);
    tick(4'b0000, 2'd3, 1'b0);
    chk("inverte_0", 32'({andar_destino, subindo}), 32'b00_0);
    tick(4'b0000, 2'd2, 1'b0);
    tick(4'b0000, 2'd1, 1'b0);
    tick(4'b0000, 2'd0, 1'b0);
    espera_porta(2'd0, n);
    chk("pend_vazio", 32'(pendentes), 32'd0);

    // Overload freezes the door timer.
    tick(4'b0010, 2'd0, 1'b0);
    tick(4'b0000, 2'd1, 1'b0);
    for (int i = 0; i < 20; i++) tick(4'b0000, 2'd1, 1'b1);
    chk("sobrecarga_porta", 32'(porta_aberta), 32'd1);
    espera_porta(2'd1, n);
    chk("dwell_pos_sobrecarga", 32'(n), 32'(TEMPO));

    // Same-floor call: never latched, reloads the timer.
    tick(4'b0100, 2'd1, 1'b0);
    tick(4'b0000, 2'd2, 1'b0);
    espera_porta(2'd2, n);
    tick(4'b0100, 2'd2, 1'b0);
    chk("mesmo_andar", 32'({porta_aberta, pendentes}), 32'b1_0000);
    for (int i = 0; i < 3; i++) tick(4'b0000, 2'd2, 1'b0);
    tick(4'b0100, 2'd2, 1'b0);
    chk("recarga_pend", 32'(pendentes), 32'd0);
    espera_porta(2'd2, n);
    chk("dwell_recarga", 32'(n), 32'(TEMPO));

    // Asynchronous reset while travelling with calls pending.
    tick(4'b1010, 2'd2, 1'b0);
    chk("movendo_1010", 32'({pendentes, parado}), 32'b1010_0);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_async", 32'({andar_destino, pendentes, porta_aberta, subindo, parado}), 32'h003);
    model_reset();
    #2 reset_n = 1'b1;

    // Random traffic with the car following the model's target.
    cur = 2;
    for (int i = 0; i < 400; i++) begin
      if (m_st == 1 && cur != m_dest && $urandom_range(0, 2) == 0)
        cur = (m_dest > cur) ? cur + 1 : cur - 1;
      ch = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      al = ($urandom_range(0, 9) == 0);
      tick(ch, 2'(cur), al);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
